// File: rtl/cache_types.sv
// Shared types and geometry for the direct-mapped L1 cache.
package cache_types;

  localparam int S_INDEX_C  = 4;
  localparam int S_OFFSET_C = 5;
  localparam int NUM_SETS   = 1 << S_INDEX_C;
  localparam int TAG_W      = 32 - S_OFFSET_C - S_INDEX_C;

  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [S_INDEX_C-1:0] index_t;
  typedef logic [255:0]         line_t;

  typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} cache_state_t;

  // Place a 4-bit word byte mask at its byte lanes within a 32-byte line.
  function automatic logic [31:0] line_byte_en(input logic [2:0] word, input logic [3:0] mask);
    return 32'(mask) << {word, 2'b00};
  endfunction

endpackage

// File: rtl/cache_array.sv
// Per-set storage: line data, tag, valid and dirty bits. Combinational read by index,
// synchronous byte-granular write.
module cache_array
  import cache_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  index_t      i_index,
  input  logic [31:0] i_byte_we,
  input  line_t       i_wline,
  input  logic        i_fill,
  input  tag_t        i_wtag,
  input  logic        i_set_dirty,
  output line_t       o_line,
  output tag_t        o_tag,
  output logic        o_valid,
  output logic        o_dirty
);

  line_t               r_data [NUM_SETS];
  tag_t                r_tag  [NUM_SETS];
  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;

  // Byte-lane merge into the selected line; full-line fills enable every lane.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 32; b++) begin
      if (i_byte_we[b]) r_data[i_index][b*8 +: 8] <= i_wline[b*8 +: 8];
    end
  end

  // Tag is captured only when a line is allocated.
  always_ff @(posedge clk) begin
    if (i_fill) r_tag[i_index] <= i_wtag;
  end

  // Valid/dirty bookkeeping; a fill leaves the line clean, a write hit dirties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= 1'b0;
    end else if (i_set_dirty) begin
      r_dirty[i_index] <= 1'b1;
    end
  end

  assign o_line  = r_data[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache: FSM, hit compare,
// byte-enable expansion and pmem muxing around cache_array.
module l1_cache
  import cache_types::*;
#(
  parameter int S_INDEX  = S_INDEX_C,
  parameter int S_OFFSET = S_OFFSET_C
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  cache_state_t r_state;
  cache_state_t w_next;

  tag_t        w_req_tag;
  index_t      w_index;
  logic [2:0]  w_word;
  logic        w_unused;

  line_t       w_line;
  tag_t        w_tag;
  logic        w_valid;
  logic        w_dirty;
  logic        w_hit;

  logic [31:0] w_byte_we;
  line_t       w_wline;
  logic        w_fill;
  logic        w_set_dirty;

  assign w_req_tag = mem_address[31:S_OFFSET+S_INDEX];
  assign w_index   = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign w_word    = mem_address[S_OFFSET-1:2];
  assign w_unused  = &{1'b0, mem_address[1:0]};

  assign w_hit = w_valid && (w_tag == w_req_tag);

  cache_array u_array (
    .clk         (clk),
    .rst         (rst),
    .i_index     (w_index),
    .i_byte_we   (w_byte_we),
    .i_wline     (w_wline),
    .i_fill      (w_fill),
    .i_wtag      (w_req_tag),
    .i_set_dirty (w_set_dirty),
    .o_line      (w_line),
    .o_tag       (w_tag),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty)
  );

  // State register; reset aborts any transaction and drops pmem strobes at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next state, CPU/pmem outputs and array write controls.
  always_comb begin
    w_next       = r_state;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    w_byte_we    = '0;
    w_wline      = {8{mem_wdata}};
    w_fill       = 1'b0;
    w_set_dirty  = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_read || mem_write) w_next = CHECK;
      end
      CHECK: begin
        if (w_hit) begin
          mem_resp  = 1'b1;
          mem_rdata = w_line[{w_word, 5'b00000} +: 32];
          w_next    = IDLE;
          if (mem_write) begin
            w_byte_we   = line_byte_en(w_word, mem_byte_enable);
            w_set_dirty = 1'b1;
          end
        end else if (w_dirty) begin
          w_next = WB;
        end else begin
          w_next = FILL;
        end
      end
      WB: begin
        pmem_write   = 1'b1;
        pmem_address = {w_tag, w_index, {S_OFFSET{1'b0}}};
        pmem_wdata   = w_line;
        if (pmem_resp) w_next = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {w_req_tag, w_index, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          w_fill    = 1'b1;
          w_byte_we = '1;
          w_wline   = pmem_rdata;
          w_next    = CHECK;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Simultaneous read and write is a CPU protocol error; the FSM lets write win.
  a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst) !(mem_read && mem_write));

endmodule
